// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a pixel-rate divider drives h/v counters, and
// every output is registered and decoded from the next counter values.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             h_sync,
  output logic             v_sync,
  output logic             v_blank,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_param
      $error("vga_timing_gen: CLK_DIV and all timing parameters must be >= 1");
    end
    if ((longint'(H_TOTAL) - 1) > ((longint'(1) << CNT_W) - 1) ||
        (longint'(V_TOTAL) - 1) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_width
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic             HP       = (H_POL != 0);
  localparam logic             VP       = (V_POL != 0);

  logic [DIV_W-1:0] div;
  logic             wrap;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;

  always_comb begin
    wrap  = en && (div == DIV_LAST);
    h_nxt = pixel_x;
    v_nxt = pixel_y;
    if (pixel_x == H_LAST) begin
      h_nxt = '0;
      v_nxt = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
    end else begin
      h_nxt = pixel_x + 1'b1;
    end
  end

  // pixel_x/pixel_y are the counters themselves; decodes use the next values
  // so every output changes on the same edge as the position it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      p_tick      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      video_on    <= 1'b0;
      v_blank     <= 1'b1;
      h_sync      <= ~HP;
      v_sync      <= ~VP;
    end else begin
      p_tick      <= wrap;
      line_start  <= wrap && (h_nxt == '0);
      frame_start <= wrap && (h_nxt == '0) && (v_nxt == '0);
      if (en) begin
        div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      end
      if (wrap) begin
        pixel_x  <= h_nxt;
        pixel_y  <= v_nxt;
        video_on <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
        v_blank  <= (v_nxt >= V_ACT);
        h_sync   <= (h_nxt >= HS_START && h_nxt <= HS_END) ? HP : ~HP;
        v_sync   <= (v_nxt >= VS_START && v_nxt <= VS_END) ? VP : ~VP;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 14x7 raster: directed vector table plus
// multi-cycle sequences for frame period, mid-frame reset and CLK_DIV=1.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, en = 1'b0;
  logic reset_b = 1'b1, en_b = 1'b1;

  logic        p_a, von_a, hs_a, vs_a, vb_a, ls_a, fs_a;
  logic [10:0] x_a, y_a;
  logic        p_b, von_b, hs_b, vs_b, vb_b, ls_b, fs_b;
  logic [10:0] x_b, y_b;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(2), .CNT_W(11)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en), .p_tick(p_a),
    .pixel_x(x_a), .pixel_y(y_a), .video_on(von_a), .h_sync(hs_a),
    .v_sync(vs_a), .v_blank(vb_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(1), .CNT_W(11)
  ) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .p_tick(p_b),
    .pixel_x(x_b), .pixel_y(y_b), .video_on(von_b), .h_sync(hs_b),
    .v_sync(vs_b), .v_blank(vb_b), .line_start(ls_b), .frame_start(fs_b)
  );

  typedef struct {
    logic rst; logic en;
    logic p; int x; int y;
    logic von; logic hs; logic vs; logic vb; logic ls; logic fs;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic e, input logic p, input int x,
                              input int y, input logic von, input logic hs, input logic vs,
                              input logic vb, input logic ls, input logic fs);
    vec_t v;
    v.rst = rst; v.en = e; v.p = p; v.x = x; v.y = y;
    v.von = von; v.hs = hs; v.vs = vs; v.vb = vb; v.ls = ls; v.fs = fs;
    return v;
  endfunction

  task automatic chk_a(input string tag, input vec_t v);
    cmp({tag, ".p_tick"},      int'(p_a),   int'(v.p));
    cmp({tag, ".pixel_x"},     int'(x_a),   v.x);
    cmp({tag, ".pixel_y"},     int'(y_a),   v.y);
    cmp({tag, ".video_on"},    int'(von_a), int'(v.von));
    cmp({tag, ".h_sync"},      int'(hs_a),  int'(v.hs));
    cmp({tag, ".v_sync"},      int'(vs_a),  int'(v.vs));
    cmp({tag, ".v_blank"},     int'(vb_a),  int'(v.vb));
    cmp({tag, ".line_start"},  int'(ls_a),  int'(v.ls));
    cmp({tag, ".frame_start"}, int'(fs_a),  int'(v.fs));
  endtask

  // Expected outputs k clks after a frame_start, derived from elapsed pixels.
  task automatic chk_clk(input string tag, input int k, input int dv, input logic p,
                         input logic [10:0] x, input logic [10:0] y, input logic von,
                         input logic hs, input logic vs, input logic vb, input logic ls,
                         input logic fs);
    int n, ex, ey;
    logic ep;
    n  = k / dv;
    ex = n % 14;
    ey = (n / 14) % 7;
    ep = ((k % dv) == 0);
    cmp($sformatf("%s.p_tick@%0d", tag, k),      int'(p),   int'(ep));
    cmp($sformatf("%s.pixel_x@%0d", tag, k),     int'(x),   ex);
    cmp($sformatf("%s.pixel_y@%0d", tag, k),     int'(y),   ey);
    cmp($sformatf("%s.video_on@%0d", tag, k),    int'(von), int'(ex < 8 && ey < 4));
    cmp($sformatf("%s.h_sync@%0d", tag, k),      int'(hs),  int'(!(ex >= 10 && ex <= 12)));
    cmp($sformatf("%s.v_sync@%0d", tag, k),      int'(vs),  int'(ey != 5));
    cmp($sformatf("%s.v_blank@%0d", tag, k),     int'(vb),  int'(ey >= 4));
    cmp($sformatf("%s.line_start@%0d", tag, k),  int'(ls),  int'(ep && ex == 0));
    cmp($sformatf("%s.frame_start@%0d", tag, k), int'(fs),  int'(ep && ex == 0 && ey == 0));
  endtask

  vec_t tbl[17];
  vec_t rst_state;

  initial begin
    int hs_low, von_low, period;
    logic reached;

    rst_state = mk(1, 1, 0, 13, 6, 0, 1, 1, 1, 0, 0);
    tbl[0]  = rst_state;
    tbl[1]  = mk(0, 1, 0, 13, 6, 0, 1, 1, 1, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1);
    tbl[3]  = mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 2, 0, 1, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 2, 0, 1, 1, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 3, 0, 1, 1, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 3, 0, 1, 1, 1, 0, 0, 0);
    for (int i = 10; i < 15; i++) tbl[i] = mk(0, 0, 0, 3, 0, 1, 1, 1, 0, 0, 0);
    tbl[15] = mk(0, 1, 1, 4, 0, 1, 1, 1, 0, 0, 0);
    tbl[16] = mk(0, 1, 0, 4, 0, 1, 1, 1, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].rst;
      en    = tbl[i].en;
      step();
      chk_a($sformatf("vec%0d", i), tbl[i]);
    end

    // Full frame with CLK_DIV=2, timed from the first frame_start after reset.
    reset = 1'b1; en = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8 && !fs_a; i++) step();
    cmp("a.first_frame_start_seen", int'(fs_a), 1);
    hs_low = 0; von_low = 0; period = 0;
    if (fs_a) begin
      chk_clk("a", 0, 2, p_a, x_a, y_a, von_a, hs_a, vs_a, vb_a, ls_a, fs_a);
      if (!hs_a) hs_low++;
      if (!von_a) von_low++;
      for (int k = 1; k <= 196; k++) begin
        step();
        chk_clk("a", k, 2, p_a, x_a, y_a, von_a, hs_a, vs_a, vb_a, ls_a, fs_a);
        if (k < 28 && !hs_a) hs_low++;
        if (k < 28 && !von_a) von_low++;
        if (fs_a && period == 0) period = k;
      end
    end
    cmp("a.line0_hsync_low_clks", hs_low, 6);
    cmp("a.line0_video_off_clks", von_low, 12);
    cmp("a.frame_period", period, 196);

    // Mid-frame reset at (6,2) with en low.
    reached = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (x_a == 11'd6 && y_a == 11'd2) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    cmp("a.reached_6_2", int'(reached), 1);
    en = 1'b0; reset = 1'b1;
    step();
    chk_a("midreset", rst_state);
    reset = 1'b0; en = 1'b1;
    step();
    chk_a("rel_clk1", tbl[1]);
    step();
    chk_a("rel_clk2", tbl[2]);

    // CLK_DIV=1 instance: reset state, then one full frame.
    cmp("b.reset.pixel_x", int'(x_b), 13);
    cmp("b.reset.pixel_y", int'(y_b), 6);
    cmp("b.reset.p_tick", int'(p_b), 0);
    cmp("b.reset.v_blank", int'(vb_b), 1);
    cmp("b.reset.video_on", int'(von_b), 0);
    cmp("b.reset.syncs", int'({hs_b, vs_b}), 3);
    reset_b = 1'b0;
    step();
    period = 0;
    chk_clk("b", 0, 1, p_b, x_b, y_b, von_b, hs_b, vs_b, vb_b, ls_b, fs_b);
    for (int k = 1; k <= 98; k++) begin
      step();
      chk_clk("b", k, 1, p_b, x_b, y_b, von_b, hs_b, vs_b, vb_b, ls_b, fs_b);
      if (fs_b && period == 0) period = k;
    end
    cmp("b.frame_period", period, 98);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
